// File: rtl/mem_access_wb_stage_if.sv
// Signal bundle for mem_access_wb_stage: EX/MEM inputs, data-bus handshake, stall/fault
// and MEM/WB outputs. The master modport is the stage itself; slave is its environment.
interface mem_access_wb_stage_if;
  logic        RF_WENM;
  logic        DM_WENM;
  logic [1:0]  sel_ldM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;
  logic [31:0] alu_outM;
  logic [31:0] dm_wdM;
  logic [31:0] PCp4M;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        stall_mem;
  logic        misalign_err;
  logic        RF_WENW;
  logic [1:0]  sel_ldW;
  logic [4:0]  rdW;
  logic [31:0] alu_outW;
  logic [31:0] ld_dataW;
  logic [31:0] PCp4W;

  modport master (
    input  RF_WENM, DM_WENM, sel_ldM, funct3M, rdM, alu_outM, dm_wdM, PCp4M,
           dbus_ack, dbus_rdata,
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be, stall_mem, misalign_err,
           RF_WENW, sel_ldW, rdW, alu_outW, ld_dataW, PCp4W
  );

  modport slave (
    output RF_WENM, DM_WENM, sel_ldM, funct3M, rdM, alu_outM, dm_wdM, PCp4M,
           dbus_ack, dbus_rdata,
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be, stall_mem, misalign_err,
           RF_WENW, sel_ldW, rdW, alu_outW, ld_dataW, PCp4W
  );
endinterface

// File: rtl/mem_access_wb_stage.sv
// MEM-stage data-bus access unit fused with the MEM/WB pipeline register.
// Define MEM_TIMEOUT_EN to abort bus waits after TIMEOUT_CYC stalled cycles.
module mem_access_wb_stage #(
  parameter int TIMEOUT_CYC = 16
) (
  input logic                   clk,
  input logic                   rst,
  mem_access_wb_stage_if.master bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  w_a;
  logic        w_is_store;
  logic        w_is_load;
  logic        w_access;
  logic        w_code_ok;
  logic        w_bad;
  logic        w_tmo;
  logic        w_want;
  logic        w_abort;
  logic        w_req;
  logic        w_complete;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        r_rf_wen;
  logic [1:0]  r_sel_ld;
  logic [4:0]  r_rd;
  logic [31:0] r_alu_out;
  logic [31:0] r_ld_data;
  logic [31:0] r_pcp4;
  logic        r_misalign;

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] a,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'h000000, b};
      3'b101:  load_extend = {16'h0000, h};
      default: load_extend = rdata;
    endcase
  endfunction

  // Access decode plus width-code legality and alignment check
  always_comb begin
    w_a        = bus.alu_outM[1:0];
    w_is_store = bus.DM_WENM;
    w_is_load  = !bus.DM_WENM && (bus.sel_ldM == 2'b01);
    w_access   = w_is_store || w_is_load;
    case (bus.funct3M)
      3'b000, 3'b001, 3'b010: w_code_ok = 1'b1;
      3'b100, 3'b101:         w_code_ok = w_is_load;
      default:                w_code_ok = 1'b0;
    endcase
    w_bad = w_access && (!w_code_ok
                         || ((bus.funct3M[1:0] == 2'b01) && w_a[0])
                         || ((bus.funct3M[1:0] == 2'b10) && (w_a != 2'b00)));
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  // Counts WAIT cycles; cleared whenever the FSM is idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  // The initial IDLE request cycle counts as one stalled cycle of the budget
  assign w_tmo = (r_state == ST_WAIT) && (r_wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
  logic [7:0] w_unused_tmo_cyc;
  assign w_unused_tmo_cyc = 8'(TIMEOUT_CYC);
  assign w_tmo            = 1'b0;
`endif

  // Request/abort/complete; an ack in the timeout cycle still completes the transfer
  always_comb begin
    w_want     = rst && w_access && !w_bad;
    w_abort    = w_want && w_tmo && !bus.dbus_ack;
    w_req      = w_want && !w_abort;
    w_complete = w_req && bus.dbus_ack;
  end

  // Byte-lane steering; lanes depend only on held inputs so they stay stable in WAIT
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0000_0000;
    if (w_is_store) begin
      case (bus.funct3M[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_a;
          w_wdata = {4{bus.dm_wdM[7:0]}};
        end
        2'b01: begin
          w_be    = w_a[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{bus.dm_wdM[15:0]}};
        end
        2'b10: begin
          w_be    = 4'b1111;
          w_wdata = bus.dm_wdM;
        end
        default: begin
          w_be    = 4'b0000;
          w_wdata = 32'h0000_0000;
        end
      endcase
    end else if (w_is_load) begin
      w_be = 4'b1111;
    end else begin
      w_be = 4'b0000;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = (w_req && !bus.dbus_ack) ? ST_WAIT : ST_IDLE;
      ST_WAIT: w_state_nxt = (w_req && !bus.dbus_ack) ? ST_WAIT : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // MEM/WB register: capture on completion or non-access, otherwise insert a bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rf_wen   <= 1'b0;
      r_sel_ld   <= 2'b00;
      r_rd       <= 5'd0;
      r_alu_out  <= 32'h0000_0000;
      r_ld_data  <= 32'h0000_0000;
      r_pcp4     <= 32'h0000_0000;
      r_misalign <= 1'b0;
    end else if (w_complete || !w_access) begin
      r_rf_wen   <= bus.RF_WENM;
      r_sel_ld   <= bus.sel_ldM;
      r_rd       <= bus.rdM;
      r_alu_out  <= bus.alu_outM;
      r_ld_data  <= (w_is_load && w_complete) ?
                    load_extend(bus.dbus_rdata, w_a, bus.funct3M) : 32'h0000_0000;
      r_pcp4     <= bus.PCp4M;
      r_misalign <= 1'b0;
    end else begin
      r_rf_wen   <= 1'b0;
      r_sel_ld   <= 2'b00;
      r_rd       <= 5'd0;
      r_alu_out  <= 32'h0000_0000;
      r_ld_data  <= 32'h0000_0000;
      r_pcp4     <= 32'h0000_0000;
      r_misalign <= w_bad || w_abort;
    end
  end

  assign bus.dbus_req     = w_req;
  assign bus.dbus_we      = bus.DM_WENM;
  assign bus.dbus_addr    = {bus.alu_outM[31:2], 2'b00};
  assign bus.dbus_wdata   = w_wdata;
  assign bus.dbus_be      = w_be;
  assign bus.stall_mem    = w_req && !bus.dbus_ack;
  assign bus.misalign_err = r_misalign;
  assign bus.RF_WENW      = r_rf_wen;
  assign bus.sel_ldW      = r_sel_ld;
  assign bus.rdW          = r_rd;
  assign bus.alu_outW     = r_alu_out;
  assign bus.ld_dataW     = r_ld_data;
  assign bus.PCp4W        = r_pcp4;

endmodule

// File: tb/tb_mem_access_wb_stage.sv
// Randomized bench for mem_access_wb_stage with a transaction-level reference model,
// a per-cycle compare process, and literal expectations for the directed scenarios.
module tb_mem_access_wb_stage;
  localparam int TMO = 4;

  typedef struct packed {
    logic        rfw;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc;
    logic        err;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_wb_stage_if u_if ();
  mem_access_wb_stage #(.TIMEOUT_CYC(TMO)) u_dut (.clk(clk), .rst(rst), .bus(u_if));

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  int          m_wait = 0;
  int          nxt_wait = 0;
  logic        exp_req, exp_stall, exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata;
  wb_t         exp_w, nxt_w;
  logic        smp_req;
  logic [3:0]  smp_be;
  logic [31:0] smp_wdata;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: what the bus and the next WB contents must be for this cycle's inputs
  function automatic void model_eval(input logic r, input logic we_m, input logic [1:0] sel,
      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
      input logic [4:0] rd, input logic rfw, input logic ack, input logic [31:0] rdata);
    int          size;
    bit          access, is_load, legal, bad, want, abort, done;
    logic [31:0] mask, val;
    access  = we_m || (sel == 2'b01);
    is_load = !we_m && (sel == 2'b01);
    size    = 1 << f3[1:0];
    legal   = (f3 <= 3'd2) || (is_load && (f3 == 3'd4 || f3 == 3'd5));
    bad     = access && (!legal || ((addr % size) != 0));
    want    = r && access && !bad;
`ifdef MEM_TIMEOUT_EN
    abort   = want && (m_wait == TMO) && !ack;
`else
    abort   = 1'b0;
`endif
    exp_req   = want && !abort;
    exp_stall = exp_req && !ack;
    exp_we    = we_m;
    exp_addr  = addr & 32'hFFFF_FFFC;
    mask      = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (we_m) begin
      case (size)
        1:       exp_be = 4'b0001 << addr[1:0];
        2:       exp_be = addr[1] ? 4'b1100 : 4'b0011;
        default: exp_be = 4'b1111;
      endcase
      exp_wdata = (size >= 4) ? wd : (wd & mask) * ((size == 1) ? 32'h0101_0101 : 32'h0001_0001);
    end else begin
      exp_be    = 4'b1111;
      exp_wdata = 32'h0;
    end
    val = (rdata >> (8 * addr[1:0])) & mask;
    if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
    done     = exp_req && ack;
    nxt_wait = !r ? 0 : (exp_stall ? m_wait + 1 : 0);
    nxt_w    = '0;
    if (r && (!access || done)) begin
      nxt_w.rfw = rfw;
      nxt_w.sel = sel;
      nxt_w.rd  = rd;
      nxt_w.alu = addr;
      nxt_w.pc  = pc;
      nxt_w.ld  = (is_load && done) ? val : 32'h0;
    end else if (r && (bad || abort)) begin
      nxt_w.err = 1'b1;
    end
  endfunction

  // Compare process: bus outputs mid-cycle and the WB register contents of this cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dbus_req", 32'(u_if.dbus_req), 32'(exp_req));
      chk("stall_mem", 32'(u_if.stall_mem), 32'(exp_stall));
      chk("dbus_addr", u_if.dbus_addr, exp_addr);
      chk("dbus_we", 32'(u_if.dbus_we), 32'(exp_we));
      if (exp_req) chk("dbus_be", 32'(u_if.dbus_be), 32'(exp_be));
      if (exp_req && exp_we) chk("dbus_wdata", u_if.dbus_wdata, exp_wdata);
      chk("RF_WENW", 32'(u_if.RF_WENW), 32'(exp_w.rfw));
      chk("sel_ldW", 32'(u_if.sel_ldW), 32'(exp_w.sel));
      chk("rdW", 32'(u_if.rdW), 32'(exp_w.rd));
      chk("alu_outW", u_if.alu_outW, exp_w.alu);
      chk("ld_dataW", u_if.ld_dataW, exp_w.ld);
      chk("PCp4W", u_if.PCp4W, exp_w.pc);
      chk("misalign_err", 32'(u_if.misalign_err), 32'(exp_w.err));
    end
  end

  task automatic drive_cycle(input logic r, input logic we_m, input logic [1:0] sel,
      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
      input logic [4:0] rd, input logic rfw, input logic ack, input logic [31:0] rdata,
      output logic stalled);
    rst             = r;
    u_if.RF_WENM    = rfw;
    u_if.DM_WENM    = we_m;
    u_if.sel_ldM    = sel;
    u_if.funct3M    = f3;
    u_if.rdM        = rd;
    u_if.alu_outM   = addr;
    u_if.dm_wdM     = wd;
    u_if.PCp4M      = pc;
    u_if.dbus_ack   = ack;
    u_if.dbus_rdata = rdata;
    model_eval(r, we_m, sel, f3, addr, wd, pc, rd, rfw, ack, rdata);
    @(negedge clk);
    smp_req   = u_if.dbus_req;
    smp_be    = u_if.dbus_be;
    smp_wdata = u_if.dbus_wdata;
    @(posedge clk);
    #1;
    exp_w   = nxt_w;
    m_wait  = nxt_wait;
    stalled = exp_stall;
  endtask

  // Present one instruction, hold it while the model says it stalls, ack after ack_dly cycles
  task automatic run_instr(input logic we_m, input logic [1:0] sel, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd, input logic rfw,
      input int ack_dly, input logic [31:0] rdata, output int n_stall);
    logic        st;
    int          c;
    logic [31:0] pc;
    pc      = $urandom;
    n_stall = 0;
    c       = 0;
    do begin
      drive_cycle(1'b1, we_m, sel, f3, addr, wd, pc, rd, rfw, (c == ack_dly),
                  (c == ack_dly) ? rdata : $urandom, st);
      if (st) n_stall++;
      c++;
    end while (st && c < 64);
    if (st) begin
      n_cmp++;
      n_bad++;
      $display("FAIL instr_bound: still stalled after %0d cycles, expected completion", c);
    end
  endtask

  initial begin
    int          ns;
    logic        st;
    logic [31:0] pc;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b0;
    u_if.RF_WENM = 1'b0; u_if.DM_WENM = 1'b0; u_if.sel_ldM = 2'b00; u_if.funct3M = 3'b000;
    u_if.rdM = 5'd0; u_if.alu_outM = 32'h0; u_if.dm_wdM = 32'h0; u_if.PCp4M = 32'h0;
    u_if.dbus_ack = 1'b0; u_if.dbus_rdata = 32'h0;
    exp_w = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    drive_cycle(1'b0, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 32'h4, 5'd1, 1'b1, 1'b0, 32'h0, st);
    chk("rst_req", 32'(smp_req), 32'h0);
    chk("rst_rfw", 32'(u_if.RF_WENW), 32'h0);

    // Zero-wait LW
    run_instr(1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 0, 32'hDEADBEEF, ns);
    chk("t1_stalls", 32'(ns), 32'd0);
    chk("t1_rfw", 32'(u_if.RF_WENW), 32'd1);
    chk("t1_rd", 32'(u_if.rdW), 32'd5);
    chk("t1_sel", 32'(u_if.sel_ldW), 32'd1);
    chk("t1_ld", u_if.ld_dataW, 32'hDEADBEEF);

    // LB / LBU with three wait cycles
    run_instr(1'b0, 2'b01, 3'b000, 32'h103, 32'h0, 5'd6, 1'b1, 3, 32'h80123456, ns);
    chk("t2_stalls", 32'(ns), 32'd3);
    chk("t2_lb", u_if.ld_dataW, 32'hFFFFFF80);
    run_instr(1'b0, 2'b01, 3'b100, 32'h103, 32'h0, 5'd6, 1'b1, 3, 32'h80123456, ns);
    chk("t2_lbu", u_if.ld_dataW, 32'h00000080);

    // SH to upper half
    run_instr(1'b1, 2'b00, 3'b001, 32'h202, 32'h0000ABCD, 5'd0, 1'b0, 0, 32'h0, ns);
    chk("t3_be", 32'(smp_be), 32'h0000000C);
    chk("t3_wdata", smp_wdata, 32'hABCDABCD);
    chk("t3_rfw", 32'(u_if.RF_WENW), 32'd0);

    // Misaligned LW
    run_instr(1'b0, 2'b01, 3'b010, 32'h101, 32'h0, 5'd7, 1'b1, 0, 32'h12345678, ns);
    chk("t4_req", 32'(smp_req), 32'd0);
    chk("t4_err", 32'(u_if.misalign_err), 32'd1);
    chk("t4_rfw", 32'(u_if.RF_WENW), 32'd0);
    run_instr(1'b0, 2'b00, 3'b000, 32'h77, 32'h0, 5'd8, 1'b1, 0, 32'h0, ns);
    chk("t4_err_pulse", 32'(u_if.misalign_err), 32'd0);

    // Reset in the middle of a pending LW, then a stray late ack
    pc = 32'h0000_1000;
    drive_cycle(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, pc, 5'd3, 1'b1, 1'b0, 32'h0, st);
    drive_cycle(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, pc, 5'd3, 1'b1, 1'b0, 32'h0, st);
    drive_cycle(1'b0, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, pc, 5'd3, 1'b1, 1'b0, 32'h0, st);
    chk("t5_req_rst", 32'(smp_req), 32'd0);
    chk("t5_rfw", 32'(u_if.RF_WENW), 32'd0);
    chk("t5_pc", u_if.PCp4W, 32'h0);
    drive_cycle(1'b1, 1'b0, 2'b00, 3'b000, 32'h55, 32'h0, pc, 5'd4, 1'b1, 1'b1, 32'h0, st);
    chk("t5_late_ack_req", 32'(smp_req), 32'd0);
    chk("t5_alu", u_if.alu_outW, 32'h55);

`ifdef MEM_TIMEOUT_EN
    // Bus never acks: abort after TMO stalled cycles
    run_instr(1'b0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd7, 1'b1, 1000, 32'h0, ns);
    chk("t6_stalls", 32'(ns), 32'(TMO));
    chk("t6_err", 32'(u_if.misalign_err), 32'd1);
    chk("t6_rfw", 32'(u_if.RF_WENW), 32'd0);
    run_instr(1'b0, 2'b00, 3'b000, 32'h1234, 32'h0, 5'd9, 1'b1, 0, 32'h0, ns);
    chk("t6_alu", u_if.alu_outW, 32'h1234);
    chk("t6_alu_rfw", 32'(u_if.RF_WENW), 32'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      int          kind;
      int          dly;
      logic        we_m;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [31:0] addr;
      kind = $urandom_range(0, 3);
      addr = $urandom;
      f3   = legal_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) addr[1:0] = f3[1] ? 2'b00 : (f3[0] ? {addr[1], 1'b0} : addr[1:0]);
      if (kind == 0) begin
        we_m = 1'b0;
        sel  = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
      end else if (kind == 3) begin
        we_m = 1'b1;
        sel  = 2'($urandom_range(0, 3));
        if (f3[2] && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
      end else begin
        we_m = 1'b0;
        sel  = 2'b01;
      end
`ifdef MEM_TIMEOUT_EN
      dly = $urandom_range(0, 6);
`else
      dly = $urandom_range(0, 3);
`endif
      run_instr(we_m, sel, f3, addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                dly, $urandom, ns);
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_wb_stage.md
Name: mem_access_wb_stage

Overview:
- MEM-stage data-memory access unit fused with the MEM/WB pipeline register.
- Consumes EX/MEM register outputs and drives a req/ack data bus.
  - Byte-lane steering and load sign/zero extension.
  - Stalls the pipeline while the bus is busy.
- Registers WB-stage control and data for the register-file write-back mux and the hazard unit.

Parameters:
- TIMEOUT_CYC, 16: bus-wait cycles before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-low reset
- RF_WENM  in  1  RF write enable of MEM instr
- DM_WENM  in  1  store indicator
- sel_ldM  in  2  WB source: 00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as ALU)
- funct3M  in  3  load/store width code
- rdM  in  5  destination register
- alu_outM  in  32  ALU result / effective address
- dm_wdM  in  32  store data (rs2)
- PCp4M  in  32  PC+4
- dbus_req  out  1  bus request
- dbus_we  out  1  write strobe
- dbus_addr  out  32  word address {alu_outM[31:2],2'b00}
- dbus_wdata  out  32  lane-steered store data
- dbus_be  out  4  byte enables
- dbus_ack  in  1  transfer complete
- dbus_rdata  in  32  read word, valid with ack
- stall_mem  out  1  freeze PC/IF/ID/EX/MEM regs
- misalign_err  out  1  one-cycle fault pulse, registered
- RF_WENW  out  1
- sel_ldW  out  2
- rdW  out  5
- alu_outW  out  32
- ld_dataW  out  32  extended load data
- PCp4W  out  32

Behaviour:
- access = DM_WENM | (sel_ldM==01).
- Legal codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
- bad = access & (illegal code | half with addr[0]=1 | word with addr[1:0]≠0).
- FSM states: IDLE, WAIT.
  - IDLE: access & !bad -> dbus_req=1 combinationally this cycle.
    - ack same cycle -> complete, stay IDLE.
    - No ack -> WAIT.
  - WAIT: dbus_req held 1 with identical addr/we/be/wdata. Upstream holds inputs via stall.
    - ack -> complete, go IDLE.
- stall_mem = dbus_req & !dbus_ack. Zero-wait access gives no stall.
- dbus_we = DM_WENM.
- Store lanes:
  - SB: be = 1<<addr[1:0]; byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011; half replicated ×2.
  - SW: be = 1111.
- Loads:
  - be = 1111.
  - Select byte/half from dbus_rdata by addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- WB register updates every cycle:
  - Complete, or non-access instr: capture RF_WENM, sel_ldM, rdM, alu_outM, PCp4M, ld_dataW.
  - Stall cycle (req & !ack): bubble. RF_WENW=0, rdW=0, sel_ldW=00, data regs 0.
  - bad: no request, no stall. Bubble into WB (RF_WENW=0). misalign_err=1 next cycle for one cycle.
- ld_dataW=0 for non-load instrs.
- Latency: inputs -> W outputs 1 cycle after completion.
- rst low (sync edge):
  - All W outputs 0, misalign_err 0, FSM IDLE.
  - dbus_req forced 0 while rst low, including mid-WAIT. Abandoned transfer is dropped.
  - A late ack while IDLE with no access is ignored.
- ack while req=0: ignored.

Optional Feature:
- MEM_TIMEOUT_EN
  - Defined: 8-bit wait counter, cleared in IDLE, increments each WAIT cycle.
    - Reaching TIMEOUT_CYC without ack: req drops, FSM -> IDLE, stall_mem deasserts.
    - WB gets a bubble; misalign_err pulses one cycle.
    - ack in the same cycle as timeout wins (normal completion).
  - Undefined: no counter; WAIT persists until ack.

Test Plan:
1. LW addr 0x100, ack same cycle, rdata 0xDEADBEEF, rd=5 -> no stall; next cycle RF_WENW=1, rdW=5, sel_ldW=01, ld_dataW=0xDEADBEEF.
2. LB addr 0x103, rdata 0x80123456, ack after 3 cycles -> stall_mem high 3 cycles, 3 WB bubbles; then ld_dataW=0xFFFFFF80. Same with LBU -> 0x00000080.
3. SH addr 0x202, dm_wdM 0x0000ABCD -> be=1100, wdata=0xABCDABCD, we=1; WB RF_WENW=0.
4. LW addr 0x101 -> dbus_req never asserted, no stall, misalign_err pulse next cycle, RF_WENW=0.
5. rst low during WAIT (cycle 2 of pending LW) -> next edge req=0, all W outputs 0; ack asserted after reset released ignored.
6. MEM_TIMEOUT_EN, TIMEOUT_CYC=4, ack never -> stall 4 cycles, req drops, misalign_err pulses, bubble, FSM IDLE; a subsequent ALU instr flows normally.
